// File: rtl/baser_pkg.sv
// Shared definitions for the BASE-R 64B/66B transmit path: MII characters,
// block type values, 7-bit control codes, state/class enums and helpers.
package baser_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int HDR_WIDTH     = 2;
    localparam int FRAME_WIDTH   = DATA_WIDTH + HDR_WIDTH;
    localparam int CTRL_WIDTH    = DATA_WIDTH / 8;
    localparam int PAYLOAD_WIDTH = DATA_WIDTH - 8;

    // MII control characters
    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;
    localparam logic [7:0] MII_SEQ   = 8'h9C;

    // Sync headers as they sit in block bits [1:0]
    localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b10;
    localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b01;

    // Block type field values
    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_OSET  = 8'h4B;

    // 7-bit control codes and the ordered-set O code
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;
    localparam logic [3:0] O_CODE_SEQ = 4'h0;

    // Error block sent whenever the transmitter enters or stays in TX_E
    localparam logic [FRAME_WIDTH-1:0] EBLOCK_T = {{CTRL_WIDTH{CODE_ERROR}}, BT_CTRL, SYNC_CTRL};

    typedef enum logic [2:0] {
        TX_INIT,
        TX_C,
        TX_D,
        TX_T,
        TX_E
    } tx_state_t;

    typedef enum logic [2:0] {
        WORD_C,
        WORD_S,
        WORD_T,
        WORD_D,
        WORD_O,
        WORD_E
    } word_class_t;

    // Idle and Error are the only control characters with a legal code
    function automatic logic [6:0] ctrl_code(input logic [7:0] lane);
        ctrl_code = (lane == MII_ERROR) ? CODE_ERROR : CODE_IDLE;
    endfunction

    // txc pattern a terminate in lane k must carry: lanes k..7 are control
    function automatic logic [7:0] term_txc(input logic [2:0] k);
        case (k)
            3'd0:    term_txc = 8'hFF;
            3'd1:    term_txc = 8'hFE;
            3'd2:    term_txc = 8'hFC;
            3'd3:    term_txc = 8'hF8;
            3'd4:    term_txc = 8'hF0;
            3'd5:    term_txc = 8'hE0;
            3'd6:    term_txc = 8'hC0;
            default: term_txc = 8'h80;
        endcase
    endfunction

    // Block type of a terminate block by terminate lane
    function automatic logic [7:0] term_block_type(input logic [2:0] k);
        case (k)
            3'd0:    term_block_type = 8'h87;
            3'd1:    term_block_type = 8'h99;
            3'd2:    term_block_type = 8'hAA;
            3'd3:    term_block_type = 8'hB4;
            3'd4:    term_block_type = 8'hCC;
            3'd5:    term_block_type = 8'hD2;
            3'd6:    term_block_type = 8'hE1;
            default: term_block_type = 8'hFF;
        endcase
    endfunction

    // Transmit state transition; an ordered set behaves exactly like a C word
    function automatic tx_state_t tx_next_state(input tx_state_t state, input word_class_t cls);
        word_class_t c;
        c = (cls == WORD_O) ? WORD_C : cls;
        tx_next_state = TX_E;
        case (state)
            TX_INIT, TX_C, TX_T: begin
                if (c == WORD_C)      tx_next_state = TX_C;
                else if (c == WORD_S) tx_next_state = TX_D;
            end
            TX_D: begin
                if (c == WORD_D)      tx_next_state = TX_D;
                else if (c == WORD_T) tx_next_state = TX_T;
            end
            TX_E: begin
                if (c == WORD_C)      tx_next_state = TX_C;
                else if (c == WORD_D) tx_next_state = TX_D;
                else if (c == WORD_T) tx_next_state = TX_T;
            end
            default: tx_next_state = TX_E;
        endcase
    endfunction

endpackage

// File: rtl/baser_66b_encoder_if.sv
// MII word input and encoded block / group / counter outputs of the encoder.
interface baser_66b_encoder_if;
    import baser_pkg::*;

    logic                   i_valid;
    logic [DATA_WIDTH-1:0]  i_txd;
    logic [CTRL_WIDTH-1:0]  i_txc;
    logic [FRAME_WIDTH-1:0] o_block;
    logic                   o_block_valid;
    logic [FRAME_WIDTH-1:0] o_tx_coded_0;
    logic [FRAME_WIDTH-1:0] o_tx_coded_1;
    logic [FRAME_WIDTH-1:0] o_tx_coded_2;
    logic [FRAME_WIDTH-1:0] o_tx_coded_3;
    logic                   o_valid;
    logic [31:0]            o_block_count;
    logic [31:0]            o_data_count;
    logic [31:0]            o_ctrl_count;
    logic [31:0]            o_err_count;

    modport master (
        output i_valid, i_txd, i_txc,
        input  o_block, o_block_valid,
        input  o_tx_coded_0, o_tx_coded_1, o_tx_coded_2, o_tx_coded_3, o_valid,
        input  o_block_count, o_data_count, o_ctrl_count, o_err_count
    );

    modport slave (
        input  i_valid, i_txd, i_txc,
        output o_block, o_block_valid,
        output o_tx_coded_0, o_tx_coded_1, o_tx_coded_2, o_tx_coded_3, o_valid,
        output o_block_count, o_data_count, o_ctrl_count, o_err_count
    );

endinterface

// File: rtl/mii_word_classifier.sv
// Combinational classification of one MII word into C/S/T/D/O/E, with the
// terminate lane and per-lane legality of control characters.
module mii_word_classifier
    import baser_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] txd,
    input  logic [CTRL_WIDTH-1:0] txc,
    output word_class_t           word_class,
    output logic [2:0]            term_pos,
    output logic [CTRL_WIDTH-1:0] lane_legal
);

    logic [7:0]            lane0;
    logic                  oset_tail_ok;
    logic                  term_hit;
    logic [2:0]            term_k;
    logic [CTRL_WIDTH-1:0] above_mask;

    assign lane0 = txd[7:0];

    // A lane is a legal control character only if it is Idle or Error
    always_comb begin
        lane_legal = '0;
        for (int k = 0; k < CTRL_WIDTH; k++) begin
            lane_legal[k] = (txd[8*k +: 8] == MII_IDLE) || (txd[8*k +: 8] == MII_ERROR);
        end
    end

    // Ordered sets may carry Idle or zero in the upper four lanes
    always_comb begin
        oset_tail_ok = 1'b1;
        for (int k = 4; k < CTRL_WIDTH; k++) begin
            if (!((txd[8*k +: 8] == MII_IDLE) || (txd[8*k +: 8] == 8'h00))) begin
                oset_tail_ok = 1'b0;
            end
        end
    end

    // Look for a terminate in lane k with the matching txc and legal lanes above it
    always_comb begin
        term_hit   = 1'b0;
        term_k     = '0;
        above_mask = '0;
        for (int k = 0; k < CTRL_WIDTH; k++) begin
            above_mask = term_txc(3'(k)) & ~(8'h01 << k);
            if ((txc == term_txc(3'(k))) && (txd[8*k +: 8] == MII_TERM) &&
                ((lane_legal & above_mask) == above_mask)) begin
                term_hit = 1'b1;
                term_k   = 3'(k);
            end
        end
    end

    // Final class; C and T0 cannot both match because lane 0 differs
    always_comb begin
        word_class = WORD_E;
        term_pos   = term_k;
        if (txc == 8'h00) begin
            word_class = WORD_D;
        end else if ((txc == 8'h01) && (lane0 == MII_START)) begin
            word_class = WORD_S;
        end else if ((txc == 8'hF1) && (lane0 == MII_SEQ) && oset_tail_ok) begin
            word_class = WORD_O;
        end else if ((txc == 8'hFF) && (&lane_legal)) begin
            word_class = WORD_C;
        end else if (term_hit) begin
            word_class = WORD_T;
        end
    end

endmodule

// File: rtl/baser_66b_encoder.sv
// BASE-R 64B/66B transmit encoder: classifies each accepted MII word, runs the
// transmit state machine, emits one 66b block per word, gathers groups of four
// blocks and keeps block/data/control/error counters.
module baser_66b_encoder
    import baser_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst,
    baser_66b_encoder_if.slave bus
);

    word_class_t              word_class;
    logic [2:0]               term_pos;
    logic [CTRL_WIDTH-1:0]    lane_legal;
    logic [DATA_WIDTH-1:0]    txd;
    logic [6:0]               lane_code [CTRL_WIDTH];
    logic [PAYLOAD_WIDTH-1:0] ctrl_payload;
    logic [PAYLOAD_WIDTH-1:0] term_payload;
    logic [FRAME_WIDTH-1:0]   normal_block;
    logic [FRAME_WIDTH-1:0]   emit_block;
    tx_state_t                state;
    tx_state_t                next_state;

    logic [FRAME_WIDTH-1:0]   block_q;
    logic                     block_valid_q;
    logic [1:0]               grp_addr;
    logic [FRAME_WIDTH-1:0]   grp_0;
    logic [FRAME_WIDTH-1:0]   grp_1;
    logic [FRAME_WIDTH-1:0]   grp_2;
    logic [FRAME_WIDTH-1:0]   coded_0;
    logic [FRAME_WIDTH-1:0]   coded_1;
    logic [FRAME_WIDTH-1:0]   coded_2;
    logic [FRAME_WIDTH-1:0]   coded_3;
    logic                     grp_valid;
    logic [31:0]              block_count;
    logic [31:0]              data_count;
    logic [31:0]              ctrl_count;
    logic [31:0]              err_count;

    assign txd = bus.i_txd;

    mii_word_classifier u_classifier (
        .txd        (bus.i_txd),
        .txc        (bus.i_txc),
        .word_class (word_class),
        .term_pos   (term_pos),
        .lane_legal (lane_legal)
    );

    // Per-lane 7-bit control codes; an illegal lane never reaches a normal encoding
    always_comb begin
        for (int k = 0; k < CTRL_WIDTH; k++) begin
            lane_code[k] = lane_legal[k] ? ctrl_code(txd[8*k +: 8]) : CODE_ERROR;
        end
    end

    // Control payloads: C packs all eight codes, Tk packs data below k and codes above k
    always_comb begin
        ctrl_payload = '0;
        term_payload = '0;
        for (int k = 0; k < CTRL_WIDTH; k++) begin
            ctrl_payload[7*k +: 7] = lane_code[k];
            if (k > int'(term_pos)) begin
                term_payload[7*k +: 7] = lane_code[k];
            end
        end
        for (int k = 0; k < CTRL_WIDTH - 1; k++) begin
            if (k < int'(term_pos)) begin
                term_payload[8*k +: 8] = txd[8*k +: 8];
            end
        end
    end

    // Normal block encoding of the current word by class
    always_comb begin
        normal_block = EBLOCK_T;
        case (word_class)
            WORD_D:  normal_block = {txd, SYNC_DATA};
            WORD_C:  normal_block = {ctrl_payload, BT_CTRL, SYNC_CTRL};
            WORD_S:  normal_block = {txd[63:8], BT_START, SYNC_CTRL};
            WORD_O:  normal_block = {28'h0, O_CODE_SEQ, txd[31:8], BT_OSET, SYNC_CTRL};
            WORD_T:  normal_block = {term_payload, term_block_type(term_pos), SYNC_CTRL};
            default: normal_block = EBLOCK_T;
        endcase
    end

    assign next_state = tx_next_state(state, word_class);
    assign emit_block = (next_state == TX_E) ? EBLOCK_T : normal_block;

    // Transmit state machine with the registered block output
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= TX_INIT;
            block_q       <= '0;
            block_valid_q <= 1'b0;
        end else begin
            block_valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                state   <= next_state;
                block_q <= emit_block;
            end
        end
    end

    // Gather four blocks per group; a reset mid-group drops what was collected
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            grp_addr  <= '0;
            grp_0     <= '0;
            grp_1     <= '0;
            grp_2     <= '0;
            coded_0   <= '0;
            coded_1   <= '0;
            coded_2   <= '0;
            coded_3   <= '0;
            grp_valid <= 1'b0;
        end else begin
            grp_valid <= 1'b0;
            if (bus.i_valid) begin
                grp_addr <= grp_addr + 2'd1;
                case (grp_addr)
                    2'd0: grp_0 <= emit_block;
                    2'd1: grp_1 <= emit_block;
                    2'd2: grp_2 <= emit_block;
                    default: begin
                        coded_0   <= grp_0;
                        coded_1   <= grp_1;
                        coded_2   <= grp_2;
                        coded_3   <= emit_block;
                        grp_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Block, data, control and error counters, all free-running and wrapping
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            block_count <= '0;
            data_count  <= '0;
            ctrl_count  <= '0;
            err_count   <= '0;
        end else if (bus.i_valid) begin
            block_count <= block_count + 32'd1;
            if (emit_block[1:0] == SYNC_DATA) begin
                data_count <= data_count + 32'd1;
            end
            if (emit_block[1:0] == SYNC_CTRL) begin
                ctrl_count <= ctrl_count + 32'd1;
            end
            if (next_state == TX_E) begin
                err_count <= err_count + 32'd1;
            end
        end
    end

    assign bus.o_block       = block_q;
    assign bus.o_block_valid = block_valid_q;
    assign bus.o_tx_coded_0  = coded_0;
    assign bus.o_tx_coded_1  = coded_1;
    assign bus.o_tx_coded_2  = coded_2;
    assign bus.o_tx_coded_3  = coded_3;
    assign bus.o_valid       = grp_valid;
    assign bus.o_block_count = block_count;
    assign bus.o_data_count  = data_count;
    assign bus.o_ctrl_count  = ctrl_count;
    assign bus.o_err_count   = err_count;

endmodule
